dna_array_ctrl: RTL and testbench

DNA_ARRAY_CTRL -- requirements
Module: dna_array_ctrl

---
 rtl/dna_array_ctrl.sv | 158 +++++++++++++++
 tb/tb_dna_array_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_array_ctrl.sv
// Sequencer for a chain of DNA PEs: streams reference bases, pads the array with DRAIN_CYC
// filler bases, then pulses done. The optional running-maximum tracker is built only when the macro DNA_CTRL_MAX_TRACK_EN is defined.
module dna_array_ctrl #(
    parameter int NUM_PE    = 16,
    parameter int DRAIN_CYC = NUM_PE * 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] ref_len_i,
    input  logic             base_valid_i,
    input  logic [1:0]       base_i,
    output logic             base_ready_o,
    output logic             pe_en_o,
    output logic [1:0]       pe_ref_o,
    input  logic [31:0]      pe_score_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      max_score_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);
    localparam logic [1:0]  PAD_BASE   = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] base_cnt_q, base_cnt_d;
    logic [CNT_W-1:0] base_cnt_inc;
    logic [15:0]      drain_cnt_q, drain_cnt_d;
    logic             pe_en_q, pe_en_d;
    logic [1:0]       pe_ref_q, pe_ref_d;
    logic             accept;
    logic             start_job;

    // Base stream handshake: a base moves when base_valid_i and base_ready_o are both high
    // at a rising edge; ready depends only on the state and abort_i, never on valid.
    assign accept       = base_valid_i & base_ready_o;
    assign base_cnt_inc = base_cnt_q + CNT_W'(1);
    assign start_job    = (state_q == IDLE) && start_i && !abort_i && (ref_len_i != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = (ref_len_i == '0) ? DONE : RUN;
                RUN:     if (accept && (base_cnt_inc == len_q)) state_d = DRAIN;
                DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        base_ready_o = (state_q == RUN) && !abort_i;
        busy_o       = (state_q == RUN) || (state_q == DRAIN);
        done_o       = (state_q == DONE);
        dbg_state_o  = state_q;
    end

    // Datapath next-state; pe_en defaults low so any non-issuing cycle stalls the array.
    always_comb begin
        len_d       = len_q;
        base_cnt_d  = base_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pe_en_d     = 1'b0;
        pe_ref_d    = pe_ref_q;
        if (!abort_i) begin
            case (state_q)
                IDLE: begin
                    if (start_job) begin
                        len_d       = ref_len_i;
                        base_cnt_d  = '0;
                        drain_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        pe_en_d    = 1'b1;
                        pe_ref_d   = base_i;
                        base_cnt_d = base_cnt_inc;
                    end
                end
                DRAIN: begin
                    pe_en_d     = 1'b1;
                    pe_ref_d    = PAD_BASE;
                    drain_cnt_d = drain_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            base_cnt_q  <= '0;
            drain_cnt_q <= '0;
            pe_en_q     <= 1'b0;
            pe_ref_q    <= PAD_BASE;
        end else begin
            len_q       <= len_d;
            base_cnt_q  <= base_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pe_en_q     <= pe_en_d;
            pe_ref_q    <= pe_ref_d;
        end
    end

    assign pe_en_o  = pe_en_q;
    assign pe_ref_o = pe_ref_q;

`ifdef DNA_CTRL_MAX_TRACK_EN
    logic [31:0] max_q, max_d;

    // A new job clears the maximum; otherwise it follows the last PE while the array is enabled.
    always_comb begin
        max_d = max_q;
        if (pe_en_q && (pe_score_i > max_q)) max_d = pe_score_i;
        if (start_job) max_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_score_o = max_q;
`else
    logic unused_score;
    assign unused_score = ^pe_score_i;
    assign max_score_o  = '0;
`endif

endmodule

// File: tb/tb_dna_array_ctrl.sv
// Bench for dna_array_ctrl: job-level model (bases left / pads left / done pending) checked
// every cycle, plus directed scenarios with hand-computed enable counts and base sequences.
module tb_dna_array_ctrl;

    localparam int CNT_W     = 4;
    localparam int DRAIN_CYC = 5;
`ifdef DNA_CTRL_MAX_TRACK_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [CNT_W-1:0] ref_len_i = '0;
    logic             base_valid_i = 1'b0;
    logic [1:0]       base_i = '0;
    logic             base_ready_o;
    logic             pe_en_o;
    logic [1:0]       pe_ref_o;
    logic [31:0]      pe_score_i = '0;
    logic             busy_o;
    logic             done_o;
    logic [31:0]      max_score_o;
    logic [1:0]       dbg_state_o;

    dna_array_ctrl #(
        .NUM_PE   (4),
        .DRAIN_CYC(DRAIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .ref_len_i   (ref_len_i),
        .base_valid_i(base_valid_i),
        .base_i      (base_i),
        .base_ready_o(base_ready_o),
        .pe_en_o     (pe_en_o),
        .pe_ref_o    (pe_ref_o),
        .pe_score_i  (pe_score_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .max_score_o (max_score_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: what is still owed to the array, and the registered outputs it implies.
    int          m_bases = 0;
    int          m_pads  = 0;
    bit          m_done  = 1'b0;
    logic        m_en    = 1'b0;
    logic [1:0]  m_ref   = 2'b11;
    logic [31:0] m_max   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bases = 0;
            m_pads  = 0;
            m_done  = 1'b0;
            m_en    = 1'b0;
            m_ref   = 2'b11;
            m_max   = '0;
        end else begin
            if (MAX_EN && m_en && (pe_score_i > m_max)) m_max = pe_score_i;
            m_en = 1'b0;
            if (abort_i) begin
                m_bases = 0;
                m_pads  = 0;
                m_done  = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_bases > 0) begin
                if (base_valid_i) begin
                    m_en  = 1'b1;
                    m_ref = base_i;
                    m_bases--;
                    if (m_bases == 0) m_pads = DRAIN_CYC;
                end
            end else if (m_pads > 0) begin
                m_en  = 1'b1;
                m_ref = 2'b11;
                m_pads--;
                if (m_pads == 0) m_done = 1'b1;
            end else if (start_i) begin
                if (ref_len_i == '0) begin
                    m_done = 1'b1;
                end else begin
                    m_bases = int'(ref_len_i);
                    m_max   = '0;
                end
            end
        end
    end

    // Per-job observations used by the directed literal checks.
    int         en_cycles = 0;
    int         en_runs   = 0;
    int         done_cnt  = 0;
    logic       prev_en   = 1'b0;
    logic [1:0] ref_q[$];
    logic [1:0] exp_q[$];

    always @(negedge clk) begin
        chk("pe_en", pe_en_o, m_en);
        chk("pe_ref", pe_ref_o, m_ref);
        chk("busy", busy_o, (m_bases > 0) || (m_pads > 0));
        chk("done", done_o, m_done);
        chk("ready", base_ready_o, (m_bases > 0) && !abort_i);
        chk("max", max_score_o, m_max);
        if (pe_en_o) begin
            en_cycles++;
            ref_q.push_back(pe_ref_o);
            if (!prev_en) en_runs++;
        end
        prev_en = pe_en_o;
        if (done_o) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mon();
        en_cycles = 0;
        en_runs   = 0;
        done_cnt  = 0;
        ref_q.delete();
    endtask

    task automatic start_job(input int len);
        start_i   = 1'b1;
        ref_len_i = CNT_W'(len);
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, done_o, 1'b1);
        tick();
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_seq_len"}, ref_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ref_q.size(); i++) begin
            chk({name, "_seq"}, ref_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pe_en", pe_en_o, 1'b0);
        chk("rst_pe_ref", pe_ref_o, 2'b11);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", base_ready_o, 1'b0);
        chk("rst_max", max_score_o, 32'd0);
        rst = 1'b0;
        tick();

        // Four bases back to back, then five pads.
        reset_mon();
        start_job(4);
        base_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            base_i = 2'(i);
            tick();
        end
        base_valid_i = 1'b0;
        wait_done("len4", 40);
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        chk_seq("len4");
        chk("len4_en_cycles", en_cycles, 9);
        chk("len4_en_runs", en_runs, 1);
        chk("len4_done_cnt", done_cnt, 1);
        chk("len4_busy_after", busy_o, 1'b0);

        // Three bases with two stall cycles between each; a start during RUN must be ignored.
        reset_mon();
        start_job(3);
        for (int b = 0; b < 3; b++) begin
            base_valid_i = 1'b1;
            base_i = 2'(2 - b);
            tick();
            base_valid_i = 1'b0;
            if (b < 2) begin
                start_i   = 1'b1;
                ref_len_i = CNT_W'(7);
                tick();
                start_i    = 1'b0;
                pe_score_i = 32'd1000;
                tick();
                pe_score_i = 32'd0;
            end
        end
        wait_done("stall", 40);
        exp_q = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        chk_seq("stall");
        chk("stall_en_cycles", en_cycles, 8);
        chk("stall_en_runs", en_runs, 3);
        chk("stall_max", max_score_o, 32'd0);

        // Zero-length job goes straight to DONE.
        reset_mon();
        start_job(0);
        @(negedge clk);
        chk("len0_done_pulse", done_o, 1'b1);
        tick();
        chk("len0_done_low", done_o, 1'b0);
        repeat (3) tick();
        chk("len0_en_cycles", en_cycles, 0);
        chk("len0_done_cnt", done_cnt, 1);

        // Abort in the second DRAIN cycle, then a normal job.
        reset_mon();
        start_job(2);
        base_valid_i = 1'b1;
        base_i = 2'd1;
        tick();
        base_i = 2'd2;
        tick();
        base_valid_i = 1'b0;
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_pe_en", pe_en_o, 1'b0);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_done", done_o, 1'b0);
        repeat (8) tick();
        chk("abort_en_cycles", en_cycles, 3);
        chk("abort_done_cnt", done_cnt, 0);
        abort_i   = 1'b1;
        start_i   = 1'b1;
        ref_len_i = CNT_W'(5);
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_beats_start", busy_o, 1'b0);
        reset_mon();
        start_job(1);
        base_valid_i = 1'b1;
        base_i = 2'd2;
        tick();
        base_valid_i = 1'b0;
        wait_done("after_abort", 40);
        chk("after_abort_en_cycles", en_cycles, 6);
        chk("after_abort_done_cnt", done_cnt, 1);

        // Score tracking: 5, 9, 7 while enabled, then lower scores during the pads.
        reset_mon();
        start_job(3);
        base_valid_i = 1'b1;
        base_i = 2'd1;
        tick();
        base_i = 2'd2;
        pe_score_i = 32'd5;
        tick();
        base_i = 2'd3;
        pe_score_i = 32'd9;
        tick();
        base_valid_i = 1'b0;
        pe_score_i = 32'd7;
        tick();
        pe_score_i = 32'd4;
        wait_done("score", 40);
        pe_score_i = 32'd0;
        chk("score_max_at_done", max_score_o, MAX_EN ? 32'd9 : 32'd0);

        // Largest length the counter can hold.
        reset_mon();
        start_job(15);
        base_valid_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            base_i = 2'(i % 4);
            tick();
        end
        base_valid_i = 1'b0;
        wait_done("len15", 40);
        chk("len15_en_cycles", en_cycles, 20);
        chk("len15_done_cnt", done_cnt, 1);

        // Reset mid-RUN: outputs return to reset values before the next edge.
        reset_mon();
        start_job(4);
        base_valid_i = 1'b1;
        base_i = 2'd1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pe_en", pe_en_o, 1'b0);
        chk("arst_pe_ref", pe_ref_o, 2'b11);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_ready", base_ready_o, 1'b0);
        chk("arst_done", done_o, 1'b0);
        chk("arst_max", max_score_o, 32'd0);
        tick();
        rst = 1'b0;
        base_valid_i = 1'b0;
        repeat (4) tick();
        chk("arst_done_cnt", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
